// File: rtl/morse_rx_decoder.sv
// Morse receiver: synchronises a photodiode level, times marks and gaps and decodes to ASCII.
// Optional glitch filter on the conditioned level is enabled by defining MORSE_RX_GLITCH_FILTER_EN.
`timescale 1ns/1ps
module morse_rx_decoder #(
   parameter int unsigned CLK_SPEED   = 16000000,
   parameter int unsigned UNIT_DIV    = 10,
   parameter int unsigned FILT_CYCLES = 4
) (
   input  logic       CLK,
   input  logic       RST_N,
   input  logic       RX_IN,
   input  logic       CHAR_READY,
   output logic [7:0] CHAR,
   output logic       CHAR_VALID,
   output logic       OVERRUN,
   output logic       STUCK,
   output logic       LED
);

   localparam int unsigned UNIT  = CLK_SPEED / UNIT_DIV;
   localparam int unsigned DUR_W = $clog2(8 * UNIT);

   // dur_q holds (cycles spent at the current level) - 1, so thresholds carry that offset.
   localparam logic [DUR_W-1:0] DUR_MAX  = '1;
   localparam logic [DUR_W-1:0] DOT_MAX  = DUR_W'(2 * UNIT - 2);
   localparam logic [DUR_W-1:0] CHAR_AT  = DUR_W'(2 * UNIT - 2);
   localparam logic [DUR_W-1:0] SPACE_AT = DUR_W'(5 * UNIT - 2);
   localparam logic [DUR_W-1:0] STUCK_AT = DUR_W'(7 * UNIT - 1);

   if (FILT_CYCLES < 1 || UNIT < 2) begin : g_param_check
      $error("morse_rx_decoder: FILT_CYCLES must be >= 1 and a unit at least 2 cycles");
   end

   typedef enum logic [1:0] {S_IDLE, S_MARK, S_GAP, S_STUCK} state_e;

   state_e           state_q, state_d;
   logic             sync1_q, sync2_q;
   logic             cond_lvl, prev_lvl_q;
   logic [DUR_W-1:0] dur_q, dur_d;
   logic [5:0]       sym_q, sym_d;
   logic [2:0]       cnt_q, cnt_d;
   logic [7:0]       char_q, char_d;
   logic             valid_q, valid_d;
   logic             overrun_q, overrun_d;
   logic             emit;
   logic [7:0]       emit_byte;
   logic             rise, fall;

   function automatic logic [7:0] decode_sym(input logic [2:0] n, input logic [5:0] s);
      case ({n, s})
         {3'd2, 6'b000001}: decode_sym = "A";
         {3'd4, 6'b001000}: decode_sym = "B";
         {3'd4, 6'b001010}: decode_sym = "C";
         {3'd3, 6'b000100}: decode_sym = "D";
         {3'd1, 6'b000000}: decode_sym = "E";
         {3'd4, 6'b000010}: decode_sym = "F";
         {3'd3, 6'b000110}: decode_sym = "G";
         {3'd4, 6'b000000}: decode_sym = "H";
         {3'd2, 6'b000000}: decode_sym = "I";
         {3'd4, 6'b000111}: decode_sym = "J";
         {3'd3, 6'b000101}: decode_sym = "K";
         {3'd4, 6'b000100}: decode_sym = "L";
         {3'd2, 6'b000011}: decode_sym = "M";
         {3'd2, 6'b000010}: decode_sym = "N";
         {3'd3, 6'b000111}: decode_sym = "O";
         {3'd4, 6'b000110}: decode_sym = "P";
         {3'd4, 6'b001101}: decode_sym = "Q";
         {3'd3, 6'b000010}: decode_sym = "R";
         {3'd3, 6'b000000}: decode_sym = "S";
         {3'd1, 6'b000001}: decode_sym = "T";
         {3'd3, 6'b000001}: decode_sym = "U";
         {3'd4, 6'b000001}: decode_sym = "V";
         {3'd3, 6'b000011}: decode_sym = "W";
         {3'd4, 6'b001001}: decode_sym = "X";
         {3'd4, 6'b001011}: decode_sym = "Y";
         {3'd4, 6'b001100}: decode_sym = "Z";
         {3'd5, 6'b011111}: decode_sym = "0";
         {3'd5, 6'b001111}: decode_sym = "1";
         {3'd5, 6'b000111}: decode_sym = "2";
         {3'd5, 6'b000011}: decode_sym = "3";
         {3'd5, 6'b000001}: decode_sym = "4";
         {3'd5, 6'b000000}: decode_sym = "5";
         {3'd5, 6'b010000}: decode_sym = "6";
         {3'd5, 6'b011000}: decode_sym = "7";
         {3'd5, 6'b011100}: decode_sym = "8";
         {3'd5, 6'b011110}: decode_sym = "9";
         default:           decode_sym = "?";
      endcase
   endfunction

   // NOTE: RX_IN is asynchronous; only sync2_q may feed any other logic.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
      end else begin
         sync1_q <= RX_IN;
         sync2_q <= sync1_q;
      end
   end

`ifdef MORSE_RX_GLITCH_FILTER_EN
   localparam int unsigned FILT_W = $clog2(FILT_CYCLES + 1);
   logic [FILT_W-1:0] filt_cnt_q, filt_cnt_d;
   logic              filt_lvl_q, filt_lvl_d;

   always_comb begin
      filt_cnt_d = '0;
      filt_lvl_d = filt_lvl_q;
      if (sync2_q != filt_lvl_q) begin
         if (filt_cnt_q == FILT_W'(FILT_CYCLES - 1)) filt_lvl_d = sync2_q;
         else                                        filt_cnt_d = filt_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         filt_cnt_q <= '0;
         filt_lvl_q <= 1'b0;
      end else begin
         filt_cnt_q <= filt_cnt_d;
         filt_lvl_q <= filt_lvl_d;
      end
   end

   assign cond_lvl = filt_lvl_q;
`else
   assign cond_lvl = sync2_q;
`endif

   assign rise = cond_lvl & ~prev_lvl_q;
   assign fall = ~cond_lvl & prev_lvl_q;

   always_comb begin
      if (rise || fall)        dur_d = '0;
      else if (dur_q != DUR_MAX) dur_d = dur_q + 1'b1;
      else                     dur_d = dur_q;
   end

   // NOTE: every signal is given a default first so no path can infer a latch.
   always_comb begin
      state_d   = state_q;
      sym_d     = sym_q;
      cnt_d     = cnt_q;
      emit      = 1'b0;
      emit_byte = 8'h00;
      unique case (state_q)
         S_IDLE: if (rise) state_d = S_MARK;
         S_MARK: begin
            if (fall) begin
               sym_d   = {sym_q[4:0], (dur_q > DOT_MAX)};
               cnt_d   = (cnt_q == 3'd7) ? cnt_q : cnt_q + 3'd1;
               state_d = S_GAP;
            end else if (dur_q == STUCK_AT) begin
               sym_d   = '0;
               cnt_d   = '0;
               state_d = S_STUCK;
            end
         end
         S_GAP: begin
            if (rise) begin
               state_d = S_MARK;
            end else if (dur_q == CHAR_AT && cnt_q != 3'd0) begin
               emit      = 1'b1;
               emit_byte = decode_sym(cnt_q, sym_q);
               sym_d     = '0;
               cnt_d     = '0;
            end else if (dur_q == SPACE_AT) begin
               emit      = 1'b1;
               emit_byte = 8'h20;
               state_d   = S_IDLE;
            end
         end
         S_STUCK: if (fall) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // A held character is never overwritten; a blocked emit only raises the sticky flag.
   always_comb begin
      char_d    = char_q;
      valid_d   = valid_q;
      overrun_d = overrun_q;
      if (emit) begin
         if (!valid_q || CHAR_READY) begin
            char_d  = emit_byte;
            valid_d = 1'b1;
         end else begin
            overrun_d = 1'b1;
         end
      end else if (valid_q && CHAR_READY) begin
         valid_d = 1'b0;
      end
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q    <= S_IDLE;
         prev_lvl_q <= 1'b0;
         dur_q      <= '0;
         sym_q      <= '0;
         cnt_q      <= '0;
         char_q     <= 8'h00;
         valid_q    <= 1'b0;
         overrun_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         prev_lvl_q <= cond_lvl;
         dur_q      <= dur_d;
         sym_q      <= sym_d;
         cnt_q      <= cnt_d;
         char_q     <= char_d;
         valid_q    <= valid_d;
         overrun_q  <= overrun_d;
      end
   end

   assign CHAR       = char_q;
   assign CHAR_VALID = valid_q;
   assign OVERRUN    = overrun_q;
   assign STUCK      = (state_q == S_STUCK);
   assign LED        = cond_lvl;

endmodule

// File: tb/tb_morse_rx_decoder.sv
// Scoreboard bench for morse_rx_decoder with U = 16 cycles; expected characters are queued by the
// stimulus and popped by an independent monitor on every CHAR_VALID && CHAR_READY transfer.
`timescale 1ns/1ps
module tb_morse_rx_decoder;

   localparam int unsigned U = 16;
`ifdef MORSE_RX_GLITCH_FILTER_EN
   localparam int LAT = 6;
`else
   localparam int LAT = 2;
`endif

   logic       clk = 1'b0;
   logic       rst_n;
   logic       rx_in;
   logic       char_ready;
   logic [7:0] rx_char;
   logic       char_valid;
   logic       overrun;
   logic       stuck;
   logic       led;

   int         checks = 0;
   int         errors = 0;
   int         xfer_count = 0;
   logic [7:0] exp_q[$];

   morse_rx_decoder #(
      .CLK_SPEED  (160),
      .UNIT_DIV   (10),
      .FILT_CYCLES(4)
   ) dut (
      .CLK       (clk),
      .RST_N     (rst_n),
      .RX_IN     (rx_in),
      .CHAR_READY(char_ready),
      .CHAR      (rx_char),
      .CHAR_VALID(char_valid),
      .OVERRUN   (overrun),
      .STUCK     (stuck),
      .LED       (led)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
      end
   endtask

   // Drive a level for n cycles; inputs change 1 ns after the rising edge.
   task automatic hold(input logic lvl, input int n);
      rx_in = lvl;
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Monitor: pops the scoreboard on each transfer and checks CHAR stability while held.
   logic [7:0] last_char;
   logic       last_hold = 1'b0;
   always @(negedge clk) begin
      if (!rst_n) begin
         last_hold = 1'b0;
      end else begin
         if (last_hold) check("char_stable", rx_char, last_char);
         if (char_valid && char_ready) begin
            xfer_count++;
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_char: got=%02h expected=none", rx_char);
            end else begin
               check("char_xfer", rx_char, exp_q.pop_front());
            end
         end
         last_hold = char_valid && !char_ready;
         last_char = rx_char;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1);
   end

   initial begin
      int base;
      logic led_hi;
      rst_n      = 1'b0;
      rx_in      = 1'b0;
      char_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_char", rx_char, 8'h00);
      check("rst_valid", char_valid, 1'b0);
      check("rst_overrun", overrun, 1'b0);
      check("rst_stuck", stuck, 1'b0);
      check("rst_led", led, 1'b0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      hold(0, 10);

      // 'L' = .-.. then a word space
      exp_q.push_back("L");
      exp_q.push_back(" ");
      hold(1, U);   hold(0, U);
      hold(1, 3*U); hold(0, U);
      hold(1, U);   hold(0, U);
      hold(1, U);   hold(0, 40);
      hold(0, 80);

      // 'E' then long idle: exactly one character and one space
      base = xfer_count;
      exp_q.push_back("E");
      exp_q.push_back(" ");
      hold(1, U); hold(0, 200);
      check("e_xfer_count", xfer_count - base, 2);

      // seven dots overflow the symbol register
      exp_q.push_back("?");
      exp_q.push_back(" ");
      repeat (7) begin
         hold(1, U); hold(0, U);
      end
      hold(0, 120);

      // stuck mark: STUCK rises exactly when the mark reaches 7U+1 conditioned cycles
      base = xfer_count;
      rx_in = 1'b1;
      repeat (LAT + 112) @(posedge clk);
      @(negedge clk);
      check("stuck_before", stuck, 1'b0);
      @(posedge clk);
      @(negedge clk);
      check("stuck_at_113", stuck, 1'b1);
      repeat (150 - (LAT + 113)) @(posedge clk);
      #1;
      check("stuck_held", stuck, 1'b1);
      hold(0, 20);
      check("stuck_after_fall", stuck, 1'b0);
      hold(0, 100);
      check("stuck_no_char", xfer_count - base, 0);

      // short pulses inside a gap: filtered away, or decoded as dots without the filter
`ifdef MORSE_RX_GLITCH_FILTER_EN
      exp_q.push_back("E");
`else
      exp_q.push_back("H");
`endif
      exp_q.push_back(" ");
      hold(1, U); hold(0, 20);
      led_hi = 1'b0;
      repeat (3) begin
         rx_in = 1'b1;
         repeat (3) begin
            @(negedge clk); led_hi |= led;
            @(posedge clk); #1;
         end
         rx_in = 1'b0;
         repeat (10) begin
            @(negedge clk); led_hi |= led;
            @(posedge clk); #1;
         end
      end
`ifdef MORSE_RX_GLITCH_FILTER_EN
      check("glitch_led", led_hi, 1'b0);
`else
      check("glitch_led", led_hi, 1'b1);
`endif
      hold(0, 120);

      // consumer stalled: 'E' held, 'T', 'E' and the space are dropped
      base = xfer_count;
      char_ready = 1'b0;
      hold(1, U);   hold(0, 3*U);
      hold(1, 3*U); hold(0, 3*U);
      hold(1, U);   hold(0, 100);
      check("ovr_char", rx_char, 8'h45);
      check("ovr_valid", char_valid, 1'b1);
      check("ovr_flag", overrun, 1'b1);
      exp_q.push_back("E");
      char_ready = 1'b1;
      hold(0, 5);
      check("ovr_drained", char_valid, 1'b0);
      check("ovr_sticky", overrun, 1'b1);
      check("ovr_xfer_count", xfer_count - base, 1);

      // reset mid-character discards the partial symbol and clears OVERRUN
      hold(1, U); hold(0, 10); hold(1, 8);
      rst_n = 1'b0;
      @(negedge clk);
      check("midrst_char", rx_char, 8'h00);
      check("midrst_overrun", overrun, 1'b0);
      check("midrst_led", led, 1'b0);
      rx_in = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      hold(0, 20);
      exp_q.push_back("T");
      exp_q.push_back(" ");
      hold(1, 3*U); hold(0, 120);
      check("final_overrun", overrun, 1'b0);

      check("queue_empty", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
